bram_wide_write_packer: RTL

BRAM_WIDE_WRITE_PACKER -- requirements
Module: bram_wide_write_packer

---
 rtl/bram_packer_pkg.sv | 13 +
 rtl/bram_packer_lane_reg.sv | 35 +++
 rtl/bram_wide_write_packer.sv | 125 ++++++++++++
 3 files changed

// File: rtl/bram_packer_pkg.sv
// Shared helpers for the wide-write packer: legal RATIO check and lane-index width.
package bram_packer_pkg;

    function automatic bit ratio_legal(input int ratio);
        return (ratio == 1) || (ratio == 2) || (ratio == 4);
    endfunction

    // Lane index needs at least one bit even when RATIO is 1.
    function automatic int lane_idx_w(input int ratio);
        return (ratio <= 2) ? 1 : $clog2(ratio);
    endfunction

endpackage

// File: rtl/bram_packer_lane_reg.sv
// One narrow lane holding register; clear wins over write enable.
module bram_packer_lane_reg #(
    parameter int NARROW_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                we,
    input  logic                clr,
    input  logic [NARROW_W-1:0] d,
    output logic [NARROW_W-1:0] q
);

    logic [NARROW_W-1:0] dat_d;
    logic [NARROW_W-1:0] dat_q;

    always_comb begin
        dat_d = dat_q;
        if (clr) begin
            dat_d = '0;
        end else if (we) begin
            dat_d = d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dat_q <= '0;
        end else begin
            dat_q <= dat_d;
        end
    end

    assign q = dat_q;

endmodule

// File: rtl/bram_wide_write_packer.sv
// Packs RATIO narrow beats into one wide RAM write; write issues one cycle after the completing beat.
// Full throughput: in_ready only drops during reset or while the address counter is being loaded.
module bram_wide_write_packer
    import bram_packer_pkg::*;
#(
    parameter int NARROW_W = 8,
    parameter int RATIO    = 4,
    parameter int ADDR_W   = 10
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [NARROW_W-1:0]          in_data,
    input  logic                         in_last,
    input  logic                         base_load,
    input  logic [ADDR_W-1:0]            base_addr,
    output logic                         wce,
    output logic [ADDR_W-1:0]            wa,
    output logic [NARROW_W*RATIO-1:0]    wd,
    output logic                         wrapped
);

    localparam int LANE_W = lane_idx_w(RATIO);
    localparam int WIDE_W = NARROW_W * RATIO;

    if (!ratio_legal(RATIO)) begin : g_bad_ratio
        $error("bram_wide_write_packer: RATIO must be 1, 2 or 4");
    end

    logic                accept;
    logic                complete;
    logic [RATIO-1:0]    lane_we;
    logic                lane_clr;
    logic [NARROW_W-1:0] lane_dat [RATIO];
    logic [WIDE_W-1:0]   wd_asm;

    logic [LANE_W-1:0]   lane_d,    lane_q;
    logic [ADDR_W-1:0]   addr_d,    addr_q;
    logic                wrapped_d, wrapped_q;
    logic                wce_d,     wce_q;
    logic [ADDR_W-1:0]   wa_d,      wa_q;
    logic [WIDE_W-1:0]   wd_d,      wd_q;

    assign in_ready = !rst && !base_load;
    assign accept   = in_valid && in_ready;
    assign complete = accept && (in_last || (lane_q == LANE_W'(RATIO - 1)));
    assign lane_clr = complete || base_load;

    // The completing beat bypasses its lane register and goes straight into wd.
    for (genvar g = 0; g < RATIO; g++) begin : g_lane
        assign lane_we[g] = accept && !complete && (lane_q == LANE_W'(g));

        bram_packer_lane_reg #(
            .NARROW_W (NARROW_W)
        ) u_lane (
            .clk (clk),
            .rst (rst),
            .we  (lane_we[g]),
            .clr (lane_clr),
            .d   (in_data),
            .q   (lane_dat[g])
        );
    end

    always_comb begin
        wd_asm = '0;
        for (int k = 0; k < RATIO; k++) begin
            if (LANE_W'(k) < lane_q) begin
                wd_asm[k*NARROW_W +: NARROW_W] = lane_dat[k];
            end else if (LANE_W'(k) == lane_q) begin
                wd_asm[k*NARROW_W +: NARROW_W] = in_data;
            end
        end
    end

    always_comb begin
        lane_d    = lane_q;
        addr_d    = addr_q;
        wrapped_d = wrapped_q;
        wce_d     = complete;
        wa_d      = wa_q;
        wd_d      = wd_q;

        if (base_load) begin
            lane_d    = '0;
            addr_d    = base_addr;
            wrapped_d = 1'b0;
        end else if (complete) begin
            lane_d = '0;
            addr_d = addr_q + ADDR_W'(1);
            wa_d   = addr_q;
            wd_d   = wd_asm;
            if (addr_q == {ADDR_W{1'b1}}) begin
                wrapped_d = 1'b1;
            end
        end else if (accept) begin
            lane_d = lane_q + LANE_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lane_q    <= '0;
            addr_q    <= '0;
            wrapped_q <= 1'b0;
            wce_q     <= 1'b0;
            wa_q      <= '0;
            wd_q      <= '0;
        end else begin
            lane_q    <= lane_d;
            addr_q    <= addr_d;
            wrapped_q <= wrapped_d;
            wce_q     <= wce_d;
            wa_q      <= wa_d;
            wd_q      <= wd_d;
        end
    end

    assign wce     = wce_q;
    assign wa      = wa_q;
    assign wd      = wd_q;
    assign wrapped = wrapped_q;

endmodule
